// File: rtl/dp_seq_ctrl.sv
// Job sequencer for dp_top: walks every split of a job through AXI load, NTT and
// URAM write-back (CTXT) or MADD (PTXT), with per-phase watchdog and error reporting.
module dp_seq_ctrl #(
  parameter int NUM_SPLIT = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_job_valid,
  output logic       o_job_ready,
  input  logic [1:0] i_job_mode,
  input  logic [2:0] i_job_nsplit,
  output logic       o_job_done,
  output logic       o_job_err,
  output logic [1:0] o_err_code,
  output logic       o_busy,
  output logic [1:0] o_mode,
  output logic [1:0] o_idx_split,
  input  logic       i_axi_done,
  output logic       o_ntt_start,
  input  logic       i_ntt_done,
  output logic       o_wruram_start,
  input  logic       i_wruram_done,
  output logic       o_madd_start,
  input  logic       i_madd_done
);

  localparam int MAX_N_SPLIT = NUM_SPLIT;
  localparam logic [2:0] NSPLIT_MAX = 3'(MAX_N_SPLIT);
  localparam logic [1:0] MODE_CTXT = 2'b01;
  localparam logic [1:0] MODE_PTXT = 2'b10;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_EARLY = 2'b11;
  // Abort when the counter would step onto all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_AXI, S_NTT_GO, S_NTT_WAIT, S_POST_GO, S_POST_WAIT, S_NEXT, S_FIN, S_ERR
  } state_t;

  state_t               state_reg, state_next;
  logic [1:0]           mode_reg, mode_next;
  logic [2:0]           nsplit_reg, nsplit_next;
  logic [1:0]           split_reg, split_next;
  logic [1:0]           err_code_reg, err_code_next;
  logic [TIMEOUT_W-1:0] wd_reg, wd_next;
  logic                 armed_reg, armed_next;
  logic                 ready_reg, busy_reg, done_reg, err_reg;
  logic                 ntt_start_reg, wruram_start_reg, madd_start_reg;

  logic       job_legal, first_wait, wd_expire, wait_state, last_split;
  logic       post_done, ntt_armed, post_rise;
  logic [1:0] post_done_vec, post_rise_vec;

  // Rising-edge detectors on the post-phase done levels (bit 1 madd, bit 0 wruram).
  assign post_done_vec = {i_madd_done, i_wruram_done};
  for (genvar gi = 0; gi < 2; gi++) begin : g_rise
    logic prev_reg;
    always_ff @(posedge clk) begin
      if (rst) prev_reg <= 1'b0;
      else     prev_reg <= post_done_vec[gi];
    end
    assign post_rise_vec[gi] = post_done_vec[gi] & ~prev_reg;
  end

  assign post_rise  = |post_rise_vec;
  assign job_legal  = ((i_job_mode == MODE_CTXT) || (i_job_mode == MODE_PTXT)) &&
                      (i_job_nsplit != 3'd0) && (i_job_nsplit <= NSPLIT_MAX);
  assign first_wait = (wd_reg == '0);
  assign wd_expire  = (wd_reg == WD_LAST);
  assign wait_state = (state_reg == S_WAIT_AXI) || (state_reg == S_NTT_WAIT) ||
                      (state_reg == S_POST_WAIT);
  assign last_split = ({1'b0, split_reg} == (nsplit_reg - 3'd1));
  assign post_done  = (mode_reg == MODE_CTXT) ? i_wruram_done : i_madd_done;
  // Early-done detection is armed only if the NTT done was low in the first wait cycle.
  assign ntt_armed  = first_wait ? ~i_ntt_done : armed_reg;

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    nsplit_next   = nsplit_reg;
    split_next    = split_reg;
    err_code_next = err_code_reg;
    armed_next    = armed_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_job_valid) begin
          mode_next     = i_job_mode;
          nsplit_next   = i_job_nsplit;
          split_next    = '0;
          err_code_next = ERR_NONE;
          if (job_legal) begin
            state_next = S_WAIT_AXI;
          end else begin
            state_next    = S_ERR;
            err_code_next = ERR_ILLEGAL;
          end
        end
      end
      S_WAIT_AXI: begin
        if (i_axi_done) begin
          state_next = S_NTT_GO;
        end else if (wd_expire) begin
          state_next    = S_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      S_NTT_GO: state_next = S_NTT_WAIT;
      S_NTT_WAIT: begin
        if (first_wait) armed_next = ~i_ntt_done;
        if (ntt_armed && post_rise) begin
          state_next    = S_ERR;
          err_code_next = ERR_EARLY;
        end else if (!first_wait && i_ntt_done) begin
          state_next = S_POST_GO;
        end else if (wd_expire) begin
          state_next    = S_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      S_POST_GO: state_next = S_POST_WAIT;
      S_POST_WAIT: begin
        if (!first_wait && post_done) begin
          state_next = S_NEXT;
        end else if (wd_expire) begin
          state_next    = S_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      S_NEXT: begin
        if (last_split) begin
          state_next = S_FIN;
        end else begin
          split_next = split_reg + 2'd1;
          // NEXT doubles as the AXI check of the following split when the load is already done.
          state_next = i_axi_done ? S_NTT_GO : S_WAIT_AXI;
        end
      end
      S_FIN:   state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_IDLE) split_next = '0;
  end

  always_comb begin
    wd_next = '0;
    if (wait_state && (state_next == state_reg)) wd_next = wd_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      mode_reg         <= '0;
      nsplit_reg       <= '0;
      split_reg        <= '0;
      err_code_reg     <= ERR_NONE;
      wd_reg           <= '0;
      armed_reg        <= 1'b0;
      ready_reg        <= 1'b1;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
      ntt_start_reg    <= 1'b0;
      wruram_start_reg <= 1'b0;
      madd_start_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mode_reg         <= mode_next;
      nsplit_reg       <= nsplit_next;
      split_reg        <= split_next;
      err_code_reg     <= err_code_next;
      wd_reg           <= wd_next;
      armed_reg        <= armed_next;
      ready_reg        <= (state_next == S_IDLE);
      busy_reg         <= (state_next != S_IDLE);
      done_reg         <= (state_next == S_FIN);
      err_reg          <= (state_next == S_ERR);
      ntt_start_reg    <= (state_next == S_NTT_GO);
      wruram_start_reg <= (state_next == S_POST_GO) && (mode_next == MODE_CTXT);
      madd_start_reg   <= (state_next == S_POST_GO) && (mode_next == MODE_PTXT);
    end
  end

  assign o_job_ready    = ready_reg;
  assign o_busy         = busy_reg;
  assign o_job_done     = done_reg;
  assign o_job_err      = err_reg;
  assign o_err_code     = err_code_reg;
  assign o_mode         = mode_reg;
  assign o_idx_split    = split_reg;
  assign o_ntt_start    = ntt_start_reg;
  assign o_wruram_start = wruram_start_reg;
  assign o_madd_start   = madd_start_reg;

endmodule
